// File: rtl/game_pkg.sv
// Shared types and widths for the invaders game-flow controller and its helpers.
package game_pkg;

    localparam int SCORE_W = 10;
    localparam int WAVE_W  = 4;
    localparam int ARRAY_W = 20;
    localparam int LINE_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        CLEAR,
        DEAD,
        OVER
    } game_state_t;

endpackage

// File: rtl/game_sequencer_pause_timer.sv
// Loadable down-counter that times the CLEAR and DEAD pauses.
// done_o is high whenever the count has reached zero.
module pause_timer #(
    parameter int PAUSE_CYCLES = 36000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic done_o
);

    localparam int CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PAUSE_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: start/play/wave-clear/death/game-over sequencing, score, lives, waves.
// Define GAME_SEQUENCER_HISCORE_EN to build the best-score register behind the hiscore port.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int BOTTOM_LINE  = 13,
    parameter int PAUSE_CYCLES = 36000000
) (
    input  logic               clk_36MHz,
    input  logic               reset,
    input  logic               start,
    input  logic [ARRAY_W-1:0] invaders_array,
    input  logic [LINE_W-1:0]  invaders_line,
    input  logic               hit,
    input  logic               player_hit,
    output logic               form_rst_n,
    output logic               level,
    output logic               play_en,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic [WAVE_W-1:0]  wave,
    output logic [SCORE_W-1:0] hiscore
);

    localparam logic [1:0]        LIVES_INIT = 2'(LIVES);
    localparam logic [LINE_W-1:0] BOTTOM     = LINE_W'(BOTTOM_LINE);

    game_state_t        state_q, state_d;
    logic               start_q, hit_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [WAVE_W-1:0]  wave_q, wave_d;
    logic               level_q, level_d;
    logic               form_rst_n_q, play_en_q, game_over_q;

    logic start_edge, hit_edge;
    logic pause_load, pause_done;

    assign start_edge = start & ~start_q;
    assign hit_edge   = hit & ~hit_q;

    // Reload the pause counter on every entry into a pause state.
    assign pause_load = ((state_d == CLEAR) || (state_d == DEAD)) && (state_d != state_q);

    pause_timer #(
        .PAUSE_CYCLES(PAUSE_CYCLES)
    ) u_pause_timer (
        .clk_i (clk_36MHz),
        .rst_ni(reset),
        .load_i(pause_load),
        .done_o(pause_done)
    );

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        wave_d  = wave_q;
        level_d = level_q;

        case (state_q)
            IDLE, OVER: begin
                if (start_edge) begin
                    state_d = LOAD;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                    wave_d  = '0;
                    level_d = 1'b0;
                end
            end
            LOAD: state_d = PLAY;
            PLAY: begin
                // Kills are scored even on the cycle the phase exits.
                if (hit_edge && (score_q != '1)) begin
                    score_d = score_q + 1'b1;
                end
                if (player_hit) begin
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = OVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = DEAD;
                    end
                end else if (invaders_line >= BOTTOM) begin
                    state_d = OVER;
                end else if (invaders_array == '0) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (pause_done) begin
                    if (wave_q != '1) begin
                        wave_d = wave_q + 1'b1;
                    end
                    level_d = 1'b1;
                    state_d = LOAD;
                end
            end
            DEAD: begin
                if (pause_done) begin
                    state_d = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            hit_q        <= 1'b0;
            score_q      <= '0;
            lives_q      <= 2'd0;
            wave_q       <= '0;
            level_q      <= 1'b0;
            form_rst_n_q <= 1'b0;
            play_en_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            hit_q        <= hit;
            score_q      <= score_d;
            lives_q      <= lives_d;
            wave_q       <= wave_d;
            level_q      <= level_d;
            form_rst_n_q <= (state_d != IDLE) && (state_d != LOAD);
            play_en_q    <= (state_d == PLAY);
            game_over_q  <= (state_d == OVER);
        end
    end

`ifdef GAME_SEQUENCER_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;

    // Captured on entry to OVER using the score that OVER will display.
    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            hiscore_q <= '0;
        end else if ((state_d == OVER) && (state_q != OVER) && (score_d > hiscore_q)) begin
            hiscore_q <= score_d;
        end
    end

    assign hiscore = hiscore_q;
`else
    assign hiscore = '0;
`endif

    assign form_rst_n = form_rst_n_q;
    assign level      = level_q;
    assign play_en    = play_en_q;
    assign game_over  = game_over_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign wave       = wave_q;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller for the invaders playfield. Sequences the invader formation through start, play, wave-clear, player-death and game-over phases, drives the formation's synchronous reset and level inputs, and keeps score, lives and wave count. Sits between the button/player logic and the formation block, watching the formation's `invaders_array`, `invaders_line` and `hit` outputs.

## Interface
Parameters:
- `LIVES`, default 3: lives at game start, range 1–3.
- `BOTTOM_LINE`, default 13: formation line that ends the game.
- `PAUSE_CYCLES`, default 36000000: length of the CLEAR and DEAD pauses in clocks; must be ≥1.

Ports:
- `clk_36MHz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  start button, level; the block acts on its rising edge only.
- `invaders_array`  in  20  formation occupancy from the formation block.
- `invaders_line`  in  4  formation row from the formation block.
- `hit`  in  1  formation hit flag; each rising edge scores one kill.
- `player_hit`  in  1  a bomb struck the player; single-cycle pulse.
- `form_rst_n`  out  1  synchronous active-low reset to the formation block.
- `level`  out  1  formation speed select; 0 on wave 0, 1 from wave 1 onward.
- `play_en`  out  1  high only in PLAY; gates player and bullet logic.
- `game_over`  out  1  high in OVER.
- `score`  out  10  kills, binary, saturates at 1023.
- `lives`  out  2  remaining lives.
- `wave`  out  4  waves cleared, saturates at 15.
- `hiscore`  out  10  best completed-game score; see Configuration.

## Operation
- States: IDLE, LOAD, PLAY, CLEAR, DEAD, OVER.
- `start_q` registers `start`; `start_edge = start & ~start_q`. `hit` is edge-detected the same way.
- IDLE: `form_rst_n`=0. On `start_edge`: score←0, lives←LIVES, wave←0, level←0, then go to LOAD.
- LOAD: `form_rst_n`=0 for exactly one cycle, then go to PLAY.
- PLAY: `play_en`=1, `form_rst_n`=1. Each `hit` rising edge adds 1 to score, saturating. Exit priority, highest first:
  - `player_hit` with lives==1: lives←0, go to OVER.
  - `player_hit` with lives>1: lives−1, go to DEAD.
  - `invaders_line` ≥ BOTTOM_LINE: go to OVER; lives unchanged.
  - `invaders_array`==0: go to CLEAR.
- CLEAR: the pause counter loads PAUSE_CYCLES−1 on entry and counts to 0. At 0: wave+1 (saturating), level←1, go to LOAD.
- DEAD: same pause as CLEAR. At 0, return to PLAY without resetting the formation.
- OVER: `game_over`=1, `form_rst_n`=1, so the formation stays frozen on screen (its tick still runs; this is accepted). On `start_edge`, apply the IDLE start initialisation and go to LOAD.
- Simultaneous events:
  - A kill edge that lands in the same cycle as a PLAY exit is still scored.
  - A `hit` edge outside PLAY is ignored.
  - `start` is ignored outside IDLE and OVER.

## Timing
- All outputs are registered and change on the clock edge after the causing input.
- `reset` low, asynchronously and mid-game included: state IDLE, `form_rst_n`=0, `level`=0, `play_en`=0, `game_over`=0, score=0, lives=0, wave=0, hiscore=0, edge registers cleared.
- Latencies:
  - `start_edge` to `play_en`=1: 2 cycles (LOAD is 1 cycle).
  - Last invader removed to `play_en`=0: 1 cycle.
  - Entering CLEAR or DEAD to the next PLAY: PAUSE_CYCLES+1 cycles for CLEAR (includes LOAD), PAUSE_CYCLES for DEAD.
- The pause counter is `$clog2(PAUSE_CYCLES)` bits wide, minimum 1.

## Configuration
- `GAME_SEQUENCER_HISCORE_EN` defined: on every entry to OVER, `hiscore` ← max(hiscore, score). Only `reset` clears it; `start` does not.
- Not defined: the `hiscore` port still exists and is tied to 0, and no register is built.

## Structure
- Shared package `game_pkg`: state enum `game_state_t`, `SCORE_W`=10, `WAVE_W`=4, `ARRAY_W`=20, `LINE_W`=4.
- One sub-module, `pause_timer`: loadable down-counter with a `done` output, parameterised on PAUSE_CYCLES.

## Test plan
Bench runs with PAUSE_CYCLES=8, LIVES=3, BOTTOM_LINE=13.
- Release reset, then pulse `start` → LOAD has `form_rst_n`=0 for 1 cycle; `play_en`=1 two cycles after the edge; lives=3, score=0.
- In PLAY, give `hit` 5 rising edges, one of them held high for 3 cycles → score=5.
- Drive `invaders_array`=0 → CLEAR; after 8 cycles plus LOAD: wave=1, level=1, `form_rst_n` pulses low once, `play_en`=1.
- Pulse `player_hit` three times, re-entering PLAY each time → lives 2, 1, 0; OVER after the third with `game_over`=1; with the macro defined, hiscore=score.
- In PLAY drive `invaders_line`=13 together with `player_hit` and lives=2 → DEAD (player_hit has priority); then hold line=13 → OVER on the first PLAY cycle.
- Assert `reset` low in CLEAR mid-pause → all outputs at reset values immediately, without waiting for a clock edge; `start` is needed to play again.
